// File: rtl/shft_left_seq.sv
// Multi-cycle logical left shifter: one bit per clock, start/done handshake.
// Optional SHFT_OVF_EN adds a sticky ovf flag for 1s shifted out of the MSB.
module shft_left_seq #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   In,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [WIDTH-1:0]   Out,
  output logic               busy,
  output logic               done
`ifdef SHFT_OVF_EN
  , output logic             ovf
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]         state;
  logic [WIDTH-1:0]   work;
  logic [SHAMT_W-1:0] cnt;
  logic               accept;
  logic [WIDTH-1:0]   in_sh1;
  logic [WIDTH-1:0]   work_sh1;
`ifdef SHFT_OVF_EN
  logic               sticky;
`endif

  assign accept   = start && (state == IDLE || state == DONE);
  assign in_sh1   = {In[WIDTH-2:0], 1'b0};
  assign work_sh1 = {work[WIDTH-2:0], 1'b0};
  assign busy     = (state == SHIFT);
  assign done     = (state == DONE);

  // The accept edge already performs the first shift, so shamt=0 and 1 both
  // complete on the accept edge and shamt=N completes N-1 edges later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      work   <= '0;
      cnt    <= '0;
      Out    <= '0;
`ifdef SHFT_OVF_EN
      sticky <= 1'b0;
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        SHIFT: begin
          work <= work_sh1;
          cnt  <= cnt - SHAMT_W'(1);
`ifdef SHFT_OVF_EN
          sticky <= sticky | work[WIDTH-1];
`endif
          if (cnt == SHAMT_W'(1)) begin
            Out   <= work_sh1;
            state <= DONE;
`ifdef SHFT_OVF_EN
            ovf   <= sticky | work[WIDTH-1];
`endif
          end
        end
        default: begin
          if (accept) begin
            if (shamt <= SHAMT_W'(1)) begin
              Out   <= (shamt == '0) ? In : in_sh1;
              state <= DONE;
`ifdef SHFT_OVF_EN
              ovf    <= (shamt != '0) & In[WIDTH-1];
              sticky <= 1'b0;
`endif
            end else begin
              work  <= in_sh1;
              cnt   <= shamt - SHAMT_W'(1);
              state <= SHIFT;
`ifdef SHFT_OVF_EN
              sticky <= In[WIDTH-1];
`endif
            end
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shft_left_seq.sv
// Scoreboard bench for shft_left_seq; checks ovf too when SHFT_OVF_EN is defined.
module tb_shft_left_seq;
  localparam int W  = 16;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  In = '0;
  logic [SW-1:0] shamt = '0;
  logic [W-1:0]  Out;
  logic          busy, done;
`ifdef SHFT_OVF_EN
  logic          ovf;
`endif

  shft_left_seq #(.WIDTH(W), .SHAMT_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .In(In), .shamt(shamt),
    .Out(Out), .busy(busy), .done(done)
`ifdef SHFT_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] out;
    logic         ovf;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   n_done = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [SW-1:0] s);
    logic [2*W-1:0] wide;
    exp_t           e;
    wide  = {{W{1'b0}}, a} << s;
    e.out = wide[W-1:0];
    e.ovf = |wide[2*W-1:W];
    return e;
  endfunction

  // Every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && done) begin
      n_done++;
      if (sb.size() == 0) chk("spurious_done", 1, 0);
      else begin
        e = sb.pop_front();
        chk("out", Out, e.out);
`ifdef SHFT_OVF_EN
        chk("ovf", ovf, e.ovf);
`endif
      end
    end
  end

  task automatic wait_done(input string tag, output int nbusy, output bit stable);
    logic [W-1:0] prev;
    bit seen;
    prev = Out; seen = 0; nbusy = 0; stable = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
      if (busy) nbusy++;
      if (Out !== prev) stable = 0;
    end
    chk({tag, "_done_seen"}, seen, 1);
  endtask

  task automatic op(input logic [W-1:0] a, input logic [SW-1:0] s, input bit poke);
    exp_t e;
    int nb;
    bit st;
    logic [W-1:0] prev;
    e = model(a, s);
    @(negedge clk);
    start = 1; In = a; shamt = s;
    sb.push_back(e);
    prev = Out; nb = 0; st = 1;
    @(posedge clk);
    #1 start = 0; In = W'($urandom); shamt = SW'($urandom);
    if (poke) begin
      // start during SHIFT must be ignored
      @(negedge clk);
      if (busy) nb++;
      if (Out !== prev) st = 0;
      start = 1; In = '1; shamt = '0;
      @(negedge clk);
      start = 0;
      if (busy) nb++;
      if (Out !== prev) st = 0;
    end
    begin
      int nb2; bit st2;
      wait_done("op", nb2, st2);
      nb += nb2; st &= st2;
    end
    chk("busy_cycles", nb, (s > 1) ? s - 1 : 0);
    chk("no_intermediate", st, 1);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    repeat (2) @(negedge clk);
    chk("out_hold", Out, e.out);
  endtask

  initial begin
    int nb, d0;
    bit st;
    exp_t e;

    #12;
    chk("rst_out", Out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
`ifdef SHFT_OVF_EN
    chk("rst_ovf", ovf, 0);
`endif
    @(negedge clk); rst_n = 1;
    repeat (2) @(negedge clk);

    op(16'h0001, 4'd4, 0);
    op(16'hA5A5, 4'd0, 0);
    op(16'h8003, 4'd15, 0);
    op(16'hC001, 4'd1, 0);

    // Ignore start during SHIFT, then restart in the DONE cycle
    op(16'h0F0F, 4'd5, 1);
    @(negedge clk);
    start = 1; In = 16'h00F0; shamt = 4'd2;
    sb.push_back(model(16'h00F0, 4'd2));
    @(posedge clk); #1 start = 0;
    wait_done("b2b_first", nb, st);
    start = 1; In = 16'h1234; shamt = 4'd1;
    e = model(16'h1234, 4'd1);
    sb.push_back(e);
    @(posedge clk); #1 start = 0; In = '1; shamt = '1;
    @(negedge clk);
    chk("b2b_done", done, 1);
    chk("b2b_out", Out, 16'h2468);
    @(negedge clk);
    chk("b2b_done_low", done, 0);

    for (int k = 0; k < 4; k++) op(W'($urandom), SW'($urandom), 0);

    // Reset mid-shift aborts and produces no done afterwards
    @(negedge clk);
    start = 1; In = 16'h00FF; shamt = 4'd8;
    @(posedge clk); #1 start = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("abort_out", Out, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
`ifdef SHFT_OVF_EN
    chk("abort_ovf", ovf, 0);
`endif
    @(negedge clk); rst_n = 1;
    d0 = n_done;
    repeat (20) @(negedge clk);
    chk("no_done_after_rst", n_done, d0);
    chk("idle_busy", busy, 0);

    op(16'h0003, 4'd14, 0);

    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
